// File: rtl/fabric3_mswitch_pkg.sv
// Shared constants for the fabric3 master-to-N-slave switch: OCP command and
// response encodings, switch FSM state encodings and bus field widths.
package fabric3_mswitch_pkg;

  // Bus field widths shared by the master side and every slave slice.
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = 4;

  // OCP MCmd encodings.
  localparam logic [2:0] MCMD_IDLE = 3'd0;
  localparam logic [2:0] MCMD_WR   = 3'd1;
  localparam logic [2:0] MCMD_RD   = 3'd2;

  // OCP SResp encodings.
  localparam logic [1:0] SRESP_NULL = 2'd0;
  localparam logic [1:0] SRESP_DVA  = 2'd1;
  localparam logic [1:0] SRESP_ERR  = 2'd3;

  // Switch FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Any non-NULL response terminates the outstanding transaction.
  function automatic logic resp_done(input logic [1:0] resp);
    return (resp != SRESP_NULL);
  endfunction

endpackage

// File: rtl/fabric3_mswitch.sv
// fabric3_mswitch: routes one OCP master to one of NPORTS slaves selected by
// i_portno. One transaction is outstanding at a time; responses are returned
// combinationally, out-of-range selects and response timeouts end in ERR.
module fabric3_mswitch
  import fabric3_mswitch_pkg::*;
#(
  parameter int NPORTS       = 5,
  parameter int PORTNO_WIDTH = 11,
  parameter int TMO_CYCLES   = 255
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [PORTNO_WIDTH-1:0]        i_portno,
  input  logic [ADDR_WIDTH-1:0]          i_ID_MAddr,
  input  logic [2:0]                     i_ID_MCmd,
  input  logic [DATA_WIDTH-1:0]          i_ID_MData,
  input  logic [BEN_WIDTH-1:0]           i_ID_MByteEn,
  output logic                           o_ID_SCmdAccept,
  output logic [DATA_WIDTH-1:0]          o_ID_SData,
  output logic [1:0]                     o_ID_SResp,
  output logic [NPORTS*ADDR_WIDTH-1:0]   o_P_MAddr,
  output logic [NPORTS*3-1:0]            o_P_MCmd,
  output logic [NPORTS*DATA_WIDTH-1:0]   o_P_MData,
  output logic [NPORTS*BEN_WIDTH-1:0]    o_P_MByteEn,
  input  logic [NPORTS-1:0]              i_P_SCmdAccept,
  input  logic [NPORTS*DATA_WIDTH-1:0]   i_P_SData,
  input  logic [NPORTS*2-1:0]            i_P_SResp,
  output logic                           o_busy,
  output logic                           o_tmo
);

  localparam int          CNT_W    = $clog2(TMO_CYCLES + 1);
  localparam logic [31:0] NPORTS_U = NPORTS;

  logic [1:0]              state_r;
  logic [1:0]              state_next_s;
  logic [1:0]              eff_state_s;
  logic [PORTNO_WIDTH-1:0] sel_q_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    busy_r;

  logic                    port_valid_s;
  logic                    cmd_active_s;
  logic                    drive_en_s;
  logic [PORTNO_WIDTH-1:0] drive_sel_s;
  logic [PORTNO_WIDTH-1:0] look_sel_s;
  logic                    sel_accept_s;
  logic [1:0]              sel_resp_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    tmo_hit_s;
  logic                    sel_load_s;
  logic                    cnt_clr_s;
  logic                    cnt_inc_s;

  // While reset is held the outputs behave as in IDLE regardless of state_r.
  assign eff_state_s  = nrst ? state_r : ST_IDLE;
  assign port_valid_s = (32'(i_portno) < NPORTS_U);
  assign cmd_active_s = (i_ID_MCmd != MCMD_IDLE);
  // The timeout fires on the NULL cycle that completes TMO_CYCLES RESP cycles.
  assign tmo_hit_s    = ((cnt_r + CNT_W'(1)) == CNT_W'(TMO_CYCLES));
  assign o_busy       = busy_r;

  // Choose which slave (if any) receives the master command fields, and
  // which slave's accept/response is observed.
  always_comb begin
    drive_en_s  = 1'b0;
    drive_sel_s = sel_q_r;
    look_sel_s  = sel_q_r;
    case (eff_state_s)
      ST_IDLE: begin
        drive_en_s  = port_valid_s;
        drive_sel_s = i_portno;
        look_sel_s  = i_portno;
      end
      ST_CMD: begin
        drive_en_s  = 1'b1;
        drive_sel_s = sel_q_r;
        look_sel_s  = sel_q_r;
      end
      default: begin
        drive_en_s  = 1'b0;
        drive_sel_s = sel_q_r;
        look_sel_s  = sel_q_r;
      end
    endcase
  end

  // Fan the master command out to the chosen slice; all other slices read zero.
  always_comb begin
    o_P_MAddr   = '0;
    o_P_MCmd    = '0;
    o_P_MData   = '0;
    o_P_MByteEn = '0;
    for (int k = 0; k < NPORTS; k++) begin
      o_P_MAddr[k*ADDR_WIDTH +: ADDR_WIDTH] =
        (drive_en_s && drive_sel_s == PORTNO_WIDTH'(k)) ? i_ID_MAddr : '0;
      o_P_MCmd[k*3 +: 3] =
        (drive_en_s && drive_sel_s == PORTNO_WIDTH'(k)) ? i_ID_MCmd : MCMD_IDLE;
      o_P_MData[k*DATA_WIDTH +: DATA_WIDTH] =
        (drive_en_s && drive_sel_s == PORTNO_WIDTH'(k)) ? i_ID_MData : '0;
      o_P_MByteEn[k*BEN_WIDTH +: BEN_WIDTH] =
        (drive_en_s && drive_sel_s == PORTNO_WIDTH'(k)) ? i_ID_MByteEn : '0;
    end
  end

  // Gather accept/response/data of the observed slave (one-hot OR mux).
  always_comb begin
    sel_accept_s = 1'b0;
    sel_resp_s   = SRESP_NULL;
    sel_data_s   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      sel_accept_s = sel_accept_s |
        ((look_sel_s == PORTNO_WIDTH'(k)) ? i_P_SCmdAccept[k] : 1'b0);
      sel_resp_s   = sel_resp_s |
        ((look_sel_s == PORTNO_WIDTH'(k)) ? i_P_SResp[k*2 +: 2] : SRESP_NULL);
      sel_data_s   = sel_data_s |
        ((look_sel_s == PORTNO_WIDTH'(k)) ? i_P_SData[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  // FSM next state plus the master-facing accept/response outputs.
  always_comb begin
    state_next_s    = eff_state_s;
    sel_load_s      = 1'b0;
    cnt_clr_s       = 1'b0;
    cnt_inc_s       = 1'b0;
    o_ID_SCmdAccept = 1'b0;
    o_ID_SResp      = SRESP_NULL;
    o_ID_SData      = '0;
    o_tmo           = 1'b0;
    case (eff_state_s)
      ST_IDLE: begin
        if (!cmd_active_s) begin
          o_ID_SCmdAccept = port_valid_s ? sel_accept_s : 1'b0;
        end else if (!port_valid_s) begin
          // Nobody to forward to: swallow the command and answer ERR.
          o_ID_SCmdAccept = 1'b1;
          state_next_s    = ST_ERR;
        end else begin
          o_ID_SCmdAccept = sel_accept_s;
          sel_load_s      = 1'b1;
          if (sel_accept_s) begin
            state_next_s = ST_RESP;
            cnt_clr_s    = 1'b1;
          end else begin
            state_next_s = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        o_ID_SCmdAccept = cmd_active_s ? sel_accept_s : 1'b0;
        if (!cmd_active_s) begin
          // Master withdrew its command; give up on this transaction.
          state_next_s = ST_IDLE;
        end else if (sel_accept_s) begin
          state_next_s = ST_RESP;
          cnt_clr_s    = 1'b1;
        end else begin
          state_next_s = ST_CMD;
        end
      end
      ST_RESP: begin
        if (resp_done(sel_resp_s)) begin
          // A real response wins even on the timeout cycle.
          o_ID_SResp   = sel_resp_s;
          o_ID_SData   = sel_data_s;
          state_next_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          o_ID_SResp   = SRESP_ERR;
          o_tmo        = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          cnt_inc_s    = 1'b1;
          state_next_s = ST_RESP;
        end
      end
      ST_ERR: begin
        o_ID_SResp   = SRESP_ERR;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, selected port, timeout counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      sel_q_r <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (sel_load_s) begin
        sel_q_r <= i_portno;
      end else begin
        sel_q_r <= sel_q_r;
      end
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_fabric3_mswitch.sv
// Directed self-checking bench for fabric3_mswitch (NPORTS=5, TMO_CYCLES=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fabric3_mswitch;
  import fabric3_mswitch_pkg::*;

  localparam int NP = 5;
  localparam int PW = 11;

  logic                     clk;
  logic                     nrst;
  logic [PW-1:0]            i_portno;
  logic [ADDR_WIDTH-1:0]    i_ID_MAddr;
  logic [2:0]               i_ID_MCmd;
  logic [DATA_WIDTH-1:0]    i_ID_MData;
  logic [BEN_WIDTH-1:0]     i_ID_MByteEn;
  logic                     o_ID_SCmdAccept;
  logic [DATA_WIDTH-1:0]    o_ID_SData;
  logic [1:0]               o_ID_SResp;
  logic [NP*ADDR_WIDTH-1:0] o_P_MAddr;
  logic [NP*3-1:0]          o_P_MCmd;
  logic [NP*DATA_WIDTH-1:0] o_P_MData;
  logic [NP*BEN_WIDTH-1:0]  o_P_MByteEn;
  logic [NP-1:0]            i_P_SCmdAccept;
  logic [NP*DATA_WIDTH-1:0] i_P_SData;
  logic [NP*2-1:0]          i_P_SResp;
  logic                     o_busy;
  logic                     o_tmo;

  int checks = 0;
  int errors = 0;

  fabric3_mswitch #(.NPORTS(NP), .PORTNO_WIDTH(PW), .TMO_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .i_portno(i_portno),
    .i_ID_MAddr(i_ID_MAddr), .i_ID_MCmd(i_ID_MCmd), .i_ID_MData(i_ID_MData),
    .i_ID_MByteEn(i_ID_MByteEn), .o_ID_SCmdAccept(o_ID_SCmdAccept),
    .o_ID_SData(o_ID_SData), .o_ID_SResp(o_ID_SResp),
    .o_P_MAddr(o_P_MAddr), .o_P_MCmd(o_P_MCmd), .o_P_MData(o_P_MData),
    .o_P_MByteEn(o_P_MByteEn), .i_P_SCmdAccept(i_P_SCmdAccept),
    .i_P_SData(i_P_SData), .i_P_SResp(i_P_SResp),
    .o_busy(o_busy), .o_tmo(o_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pcmd(input int k);
    return o_P_MCmd[k*3 +: 3];
  endfunction

  function automatic logic port_zero(input int k);
    return ~(|{o_P_MAddr[k*ADDR_WIDTH +: ADDR_WIDTH], o_P_MCmd[k*3 +: 3],
               o_P_MData[k*DATA_WIDTH +: DATA_WIDTH], o_P_MByteEn[k*BEN_WIDTH +: BEN_WIDTH]});
  endfunction

  function automatic logic all_zero();
    return port_zero(0) & port_zero(1) & port_zero(2) & port_zero(3) & port_zero(4);
  endfunction

  task automatic clear_inputs();
    i_portno       = '0;
    i_ID_MAddr     = '0;
    i_ID_MCmd      = MCMD_IDLE;
    i_ID_MData     = '0;
    i_ID_MByteEn   = '0;
    i_P_SCmdAccept = '0;
    i_P_SData      = '0;
    i_P_SResp      = '0;
  endtask

  task automatic master(input int port, input logic [2:0] cmd, input logic [31:0] addr,
                        input logic [31:0] data);
    i_portno     = PW'(port);
    i_ID_MCmd    = cmd;
    i_ID_MAddr   = addr;
    i_ID_MData   = data;
    i_ID_MByteEn = 4'hF;
  endtask

  task automatic slave_resp(input int port, input logic [1:0] resp, input logic [31:0] data);
    i_P_SResp[port*2 +: 2]                 = resp;
    i_P_SData[port*DATA_WIDTH +: DATA_WIDTH] = data;
  endtask

  initial begin
    nrst = 1'b0;
    clear_inputs();

    // ---------------- Reset ----------------
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_tmo", 64'(o_tmo), 64'h0);
    chk("rst_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    @(negedge clk); nrst = 1'b1;

    // ---------------- RD port 2, same-cycle accept, DVA at t2 ----------------
    @(negedge clk);
    master(2, MCMD_RD, 32'h0000_1000, 32'h0);
    i_P_SCmdAccept[2] = 1'b1;
    #1;
    chk("rd2_t0_accept", 64'(o_ID_SCmdAccept), 64'h1);
    chk("rd2_t0_pcmd", 64'(pcmd(2)), 64'(MCMD_RD));
    chk("rd2_t0_paddr", 64'(o_P_MAddr[2*ADDR_WIDTH +: ADDR_WIDTH]), 64'h1000);
    chk("rd2_t0_others", 64'(port_zero(0) & port_zero(1) & port_zero(3) & port_zero(4)), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rd2_t1_busy", 64'(o_busy), 64'h1);
    chk("rd2_t1_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    chk("rd2_t1_allzero", 64'(all_zero()), 64'h1);
    @(negedge clk);
    slave_resp(2, SRESP_DVA, 32'hCAFE_BABE);
    #1;
    chk("rd2_t2_resp", 64'(o_ID_SResp), 64'(SRESP_DVA));
    chk("rd2_t2_data", 64'(o_ID_SData), 64'hCAFE_BABE);
    chk("rd2_t2_others", 64'(port_zero(0) & port_zero(1) & port_zero(3) & port_zero(4)), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rd2_t3_busy", 64'(o_busy), 64'h0);

    // ---------------- WR port 1, accept after 3 cycles, portno moves to 3 ----------------
    master(1, MCMD_WR, 32'h0000_2000, 32'h1234_5678);
    #1;
    chk("wr1_t0_pcmd", 64'(pcmd(1)), 64'(MCMD_WR));
    chk("wr1_t0_accept", 64'(o_ID_SCmdAccept), 64'h0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      i_portno = PW'(3);
      #1;
      chk("wr1_cmd_busy", 64'(o_busy), 64'h1);
      chk("wr1_cmd_pcmd1", 64'(pcmd(1)), 64'(MCMD_WR));
      chk("wr1_cmd_pdata1", 64'(o_P_MData[1*DATA_WIDTH +: DATA_WIDTH]), 64'h1234_5678);
      chk("wr1_cmd_port3", 64'(port_zero(3)), 64'h1);
    end
    @(negedge clk);
    i_P_SCmdAccept[1] = 1'b1;
    i_P_SCmdAccept[3] = 1'b1;
    #1;
    chk("wr1_t3_accept", 64'(o_ID_SCmdAccept), 64'h1);
    chk("wr1_t3_pcmd1", 64'(pcmd(1)), 64'(MCMD_WR));
    chk("wr1_t3_port3", 64'(port_zero(3)), 64'h1);
    @(negedge clk);
    clear_inputs();
    slave_resp(1, SRESP_DVA, 32'h0);
    #1;
    chk("wr1_t4_resp", 64'(o_ID_SResp), 64'(SRESP_DVA));
    chk("wr1_t4_pcmd1", 64'(pcmd(1)), 64'(MCMD_IDLE));
    @(negedge clk);
    clear_inputs();

    // ---------------- Late slave response in IDLE is ignored ----------------
    i_portno = PW'(1);
    slave_resp(1, SRESP_DVA, 32'hDEAD_BEEF);
    #1;
    chk("late_idle_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    chk("late_idle_data", 64'(o_ID_SData), 64'h0);

    // ---------------- Out-of-range port 7 ----------------
    @(negedge clk);
    clear_inputs();
    master(7, MCMD_RD, 32'h0000_3000, 32'h0);
    i_P_SCmdAccept = '1;
    #1;
    chk("bad_t0_accept", 64'(o_ID_SCmdAccept), 64'h1);
    chk("bad_t0_allzero", 64'(all_zero()), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("bad_t1_resp", 64'(o_ID_SResp), 64'(SRESP_ERR));
    chk("bad_t1_data", 64'(o_ID_SData), 64'h0);
    chk("bad_t1_allzero", 64'(all_zero()), 64'h1);
    @(negedge clk); #1;
    chk("bad_t2_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    chk("bad_t2_busy", 64'(o_busy), 64'h0);

    // ---------------- Timeout: accepted, never answered ----------------
    master(0, MCMD_RD, 32'h0000_4000, 32'h0);
    i_P_SCmdAccept[0] = 1'b1;
    #1;
    chk("tmo_t0_accept", 64'(o_ID_SCmdAccept), 64'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      chk("tmo_wait_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
      chk("tmo_wait_tmo", 64'(o_tmo), 64'h0);
    end
    @(negedge clk); #1;
    chk("tmo_t4_resp", 64'(o_ID_SResp), 64'(SRESP_ERR));
    chk("tmo_t4_tmo", 64'(o_tmo), 64'h1);
    @(negedge clk);
    slave_resp(0, SRESP_DVA, 32'h5555_AAAA);
    #1;
    chk("tmo_late_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    chk("tmo_late_tmo", 64'(o_tmo), 64'h0);
    chk("tmo_late_busy", 64'(o_busy), 64'h0);

    // ---------------- DVA on the timeout cycle wins ----------------
    @(negedge clk);
    clear_inputs();
    master(0, MCMD_RD, 32'h0000_4004, 32'h0);
    i_P_SCmdAccept[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      clear_inputs();
    end
    @(negedge clk);
    slave_resp(0, SRESP_DVA, 32'h0BAD_F00D);
    #1;
    chk("race_resp", 64'(o_ID_SResp), 64'(SRESP_DVA));
    chk("race_data", 64'(o_ID_SData), 64'h0BAD_F00D);
    chk("race_tmo", 64'(o_tmo), 64'h0);

    // ---------------- Reset during RESP ----------------
    @(negedge clk);
    clear_inputs();
    master(3, MCMD_RD, 32'h0000_5000, 32'h0);
    i_P_SCmdAccept[3] = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rstmid_t1_busy", 64'(o_busy), 64'h1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rstmid_t2_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));
    @(negedge clk);
    nrst = 1'b1;
    slave_resp(3, SRESP_DVA, 32'h1111_2222);
    #1;
    chk("rstmid_t3_busy", 64'(o_busy), 64'h0);
    chk("rstmid_t3_resp", 64'(o_ID_SResp), 64'(SRESP_NULL));

    // ---------------- Master withdraws command while in CMD ----------------
    @(negedge clk);
    clear_inputs();
    master(2, MCMD_RD, 32'h0000_6000, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("drop_t1_busy", 64'(o_busy), 64'h1);
    @(negedge clk); #1;
    chk("drop_t2_busy", 64'(o_busy), 64'h0);

    // ---------------- Back-to-back RD port 0 then RD port 4 ----------------
    master(0, MCMD_RD, 32'h0000_7000, 32'h0);
    i_P_SCmdAccept[0] = 1'b1;
    #1;
    chk("b2b_a_accept", 64'(o_ID_SCmdAccept), 64'h1);
    @(negedge clk);
    #1;
    chk("b2b_resp_noaccept", 64'(o_ID_SCmdAccept), 64'h0);
    chk("b2b_resp_pcmd0", 64'(pcmd(0)), 64'(MCMD_IDLE));
    @(negedge clk);
    clear_inputs();
    slave_resp(0, SRESP_DVA, 32'hAAAA_0000);
    #1;
    chk("b2b_a_resp", 64'(o_ID_SResp), 64'(SRESP_DVA));
    chk("b2b_a_data", 64'(o_ID_SData), 64'hAAAA_0000);
    @(negedge clk);
    clear_inputs();
    master(4, MCMD_RD, 32'h0000_7004, 32'h0);
    i_P_SCmdAccept[4] = 1'b1;
    #1;
    chk("b2b_b_accept", 64'(o_ID_SCmdAccept), 64'h1);
    chk("b2b_b_pcmd4", 64'(pcmd(4)), 64'(MCMD_RD));
    chk("b2b_b_port0", 64'(port_zero(0)), 64'h1);
    @(negedge clk);
    clear_inputs();
    slave_resp(4, SRESP_DVA, 32'hBBBB_4444);
    #1;
    chk("b2b_b_resp", 64'(o_ID_SResp), 64'(SRESP_DVA));
    chk("b2b_b_data", 64'(o_ID_SData), 64'hBBBB_4444);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("b2b_end_busy", 64'(o_busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
